// File: rtl/bram_pq_pkg.sv
// Shared types and width helpers for the bram-backed priority queue controller.
package bram_pq_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, MOVE} pq_state_t;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bram_pq_min_tracker.sv
// Running minimum over a stream of (value, addr) pairs; strict less-than keeps the lowest address on ties.
module pq_min_tracker #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init,
    input  logic                  valid,
    input  logic [DATA_WIDTH-1:0] value,
    input  logic [ADDR_W-1:0]     addr,
    output logic [DATA_WIDTH-1:0] min,
    output logic [ADDR_W-1:0]     min_addr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min      <= '0;
            min_addr <= '0;
        end else if (valid && (init || value < min)) begin
            min      <= value;
            min_addr <= addr;
        end
    end

endmodule

// File: rtl/bram_pq_ctrl.sv
// Unsorted array priority queue controller: appends on enqueue, scans for the minimum on dequeue
// and refills the hole with the last entry. The bram itself lives outside this block.
module bram_pq_ctrl
    import bram_pq_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RAM_DEPTH  = 256
) (
    input  logic                           CLK,
    input  logic                           RSTn,
    input  logic                           i_enq_valid,
    input  logic [DATA_WIDTH-1:0]          i_enq_data,
    output logic                           o_enq_ready,
    input  logic                           i_deq_req,
    output logic                           o_deq_valid,
    output logic [DATA_WIDTH-1:0]          o_deq_data,
    output logic [cnt_w(RAM_DEPTH)-1:0]    o_count,
    output logic                           o_full,
    output logic                           o_empty,
    output logic                           o_busy,
    output logic                           o_write,
    output logic [addr_w(RAM_DEPTH)-1:0]   o_wrt_addr,
    output logic [DATA_WIDTH-1:0]          o_data,
    output logic                           o_read,
    output logic [addr_w(RAM_DEPTH)-1:0]   o_read_addr,
    input  logic [DATA_WIDTH-1:0]          i_data
);

    localparam int AddrW = addr_w(RAM_DEPTH);
    localparam int CntW  = cnt_w(RAM_DEPTH);

    pq_state_t             state;
    logic [CntW-1:0]       count;
    logic [AddrW-1:0]      rd_addr;
    logic                  cmp_valid;
    logic [AddrW-1:0]      cmp_addr;
    logic [DATA_WIDTH-1:0] last_val;
    logic [DATA_WIDTH-1:0] deq_data;
    logic [DATA_WIDTH-1:0] min;
    logic [AddrW-1:0]      min_addr;

    logic [CntW-1:0]  count_m1;
    logic [AddrW-1:0] last_addr;
    logic             is_empty;
    logic             is_full;
    logic             deq_start;
    logic             enq_fire;
    logic             move_write;

    assign count_m1   = count - CntW'(1);
    assign last_addr  = count_m1[AddrW-1:0];
    assign is_empty   = (count == '0);
    assign is_full    = (count == CntW'(RAM_DEPTH));
    assign deq_start  = (state == IDLE) && i_deq_req && !is_empty;
    assign o_enq_ready = (state == IDLE) && !is_full && !(i_deq_req && !is_empty);
    assign enq_fire   = o_enq_ready && i_enq_valid;
    assign move_write = (state == MOVE) && (min_addr != last_addr);

    // Read data lags the read by one cycle, so the compare stage tracks which address is arriving.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            count     <= '0;
            rd_addr   <= '0;
            cmp_valid <= 1'b0;
            cmp_addr  <= '0;
            last_val  <= '0;
            deq_data  <= '0;
        end else begin
            cmp_valid <= (state == SCAN);
            cmp_addr  <= rd_addr;
            if (cmp_valid && cmp_addr == last_addr) begin
                last_val <= i_data;
            end
            case (state)
                IDLE: begin
                    if (deq_start) begin
                        state   <= SCAN;
                        rd_addr <= '0;
                    end else if (enq_fire) begin
                        count <= count + CntW'(1);
                    end
                end
                SCAN: begin
                    if (rd_addr == last_addr) begin
                        state <= DRAIN;
                    end else begin
                        rd_addr <= rd_addr + AddrW'(1);
                    end
                end
                DRAIN: state <= MOVE;
                MOVE: begin
                    count    <= count_m1;
                    deq_data <= min;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    pq_min_tracker #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (AddrW)
    ) u_min_tracker (
        .clk      (CLK),
        .rst_n    (RSTn),
        .init     (cmp_addr == '0),
        .valid    (cmp_valid),
        .value    (i_data),
        .addr     (cmp_addr),
        .min      (min),
        .min_addr (min_addr)
    );

    assign o_deq_valid = (state == MOVE);
    assign o_deq_data  = (state == MOVE) ? min : deq_data;
    assign o_count     = count;
    assign o_full      = is_full;
    assign o_empty     = is_empty;
    assign o_busy      = (state != IDLE);

    // bram ports are combinational so the bram samples them on the same edge as the controller.
    assign o_write     = enq_fire || move_write;
    assign o_wrt_addr  = (state == MOVE) ? min_addr : (enq_fire ? count[AddrW-1:0] : '0);
    assign o_data      = (state == MOVE) ? last_val : (enq_fire ? i_enq_data : '0);
    assign o_read      = (state == SCAN);
    assign o_read_addr = (state == SCAN) ? rd_addr : '0;

endmodule

// File: tb/tb_bram_pq_ctrl.sv
// Self-checking bench: bram_pq_ctrl plus a behavioural bram, checked against a positional queue model.
module tb_bram_pq_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 256;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;

    logic          CLK;
    logic          RSTn;
    logic          i_enq_valid;
    logic [DW-1:0] i_enq_data;
    logic          o_enq_ready;
    logic          i_deq_req;
    logic          o_deq_valid;
    logic [DW-1:0] o_deq_data;
    logic [CW-1:0] o_count;
    logic          o_full;
    logic          o_empty;
    logic          o_busy;
    logic          o_write;
    logic [AW-1:0] o_wrt_addr;
    logic [DW-1:0] o_data;
    logic          o_read;
    logic [AW-1:0] o_read_addr;
    logic [DW-1:0] i_data;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] model [$];
    logic [DW-1:0] last_deq;
    int errors;
    int checks;

    bram_pq_ctrl #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH)) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .i_enq_valid (i_enq_valid),
        .i_enq_data  (i_enq_data),
        .o_enq_ready (o_enq_ready),
        .i_deq_req   (i_deq_req),
        .o_deq_valid (o_deq_valid),
        .o_deq_data  (o_deq_data),
        .o_count     (o_count),
        .o_full      (o_full),
        .o_empty     (o_empty),
        .o_busy      (o_busy),
        .o_write     (o_write),
        .o_wrt_addr  (o_wrt_addr),
        .o_data      (o_data),
        .o_read      (o_read),
        .o_read_addr (o_read_addr),
        .i_data      (i_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural dual-port bram with one cycle of read latency.
    always @(posedge CLK) begin
        if (o_write) mem[o_wrt_addr] <= o_data;
        if (o_read) i_data <= mem[o_read_addr];
    end

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_state();
        @(negedge CLK);
        #1;
        check_output("count", 64'(o_count), 64'(model.size()));
        check_output("empty", 64'(o_empty), 64'(model.size() == 0));
        check_output("full", 64'(o_full), 64'(model.size() == DEPTH));
        check_output("busy_idle", 64'(o_busy), 64'd0);
        check_output("deq_data_held", 64'(o_deq_data), 64'(last_deq));
    endtask

    task automatic check_mem();
        for (int i = 0; i < model.size(); i++) begin
            check_output($sformatf("bram[%0d]", i), 64'(mem[i]), 64'(model[i]));
        end
    endtask

    task automatic do_enqueue(input logic [DW-1:0] v);
        @(negedge CLK);
        i_enq_valid = 1'b1;
        i_enq_data  = v;
        #1;
        if (model.size() < DEPTH) begin
            check_output("enq_ready", 64'(o_enq_ready), 64'd1);
            check_output("enq_write", 64'(o_write), 64'd1);
            check_output("enq_addr", 64'(o_wrt_addr), 64'(model.size()));
            check_output("enq_data", 64'(o_data), 64'(v));
            model.push_back(v);
        end else begin
            check_output("enq_ready_full", 64'(o_enq_ready), 64'd0);
            check_output("enq_write_full", 64'(o_write), 64'd0);
        end
        @(posedge CLK);
        #1;
        i_enq_valid = 1'b0;
    endtask

    task automatic do_dequeue(input bit with_enq, input logic [DW-1:0] enq_v);
        int n;
        int idx;
        int lat;
        bit got;
        logic [DW-1:0] exp_min;
        n = model.size();
        idx = 0;
        exp_min = '0;
        for (int i = 0; i < n; i++) begin
            if (i == 0 || model[i] < exp_min) begin
                exp_min = model[i];
                idx = i;
            end
        end
        @(negedge CLK);
        i_deq_req = 1'b1;
        if (with_enq) begin
            i_enq_valid = 1'b1;
            i_enq_data  = enq_v;
        end
        #1;
        if (n > 0) begin
            check_output("enq_ready_vs_deq", 64'(o_enq_ready), 64'd0);
            check_output("no_enq_write_vs_deq", 64'(o_write), 64'd0);
        end else begin
            check_output("enq_ready_empty_deq", 64'(o_enq_ready), 64'd1);
        end
        @(posedge CLK);
        #1;
        i_deq_req   = 1'b0;
        i_enq_valid = 1'b0;
        if (n == 0) begin
            got = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge CLK);
                #1;
                if (o_busy || o_deq_valid) got = 1;
            end
            check_output("empty_deq_ignored", 64'(got), 64'd0);
            return;
        end
        lat = 0;
        got = 0;
        while (!got && lat < n + 10) begin
            @(negedge CLK);
            #1;
            lat++;
            if (o_deq_valid) got = 1;
        end
        check_output("deq_pulse_seen", 64'(got), 64'd1);
        if (got) begin
            check_output("deq_latency", 64'(lat), 64'(n + 2));
            check_output("deq_data", 64'(o_deq_data), 64'(exp_min));
            check_output("move_write", 64'(o_write), 64'(idx != n - 1));
            if (idx != n - 1) begin
                check_output("move_addr", 64'(o_wrt_addr), 64'(idx));
                check_output("move_data", 64'(o_data), 64'(model[n-1]));
            end
        end
        model[idx] = model[n-1];
        void'(model.pop_back());
        last_deq = exp_min;
        @(negedge CLK);
        #1;
        check_output("deq_single_pulse", 64'(o_deq_valid), 64'd0);
        check_state();
    endtask

    task automatic drain();
        while (model.size() > 0) do_dequeue(1'b0, '0);
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RSTn = 1'b0;
        #1;
        check_output("rst_count", 64'(o_count), 64'd0);
        check_output("rst_empty", 64'(o_empty), 64'd1);
        check_output("rst_full", 64'(o_full), 64'd0);
        check_output("rst_busy", 64'(o_busy), 64'd0);
        check_output("rst_deq_valid", 64'(o_deq_valid), 64'd0);
        check_output("rst_deq_data", 64'(o_deq_data), 64'd0);
        check_output("rst_write", 64'(o_write), 64'd0);
        check_output("rst_read", 64'(o_read), 64'd0);
        check_output("rst_wrt_addr", 64'(o_wrt_addr), 64'd0);
        check_output("rst_read_addr", 64'(o_read_addr), 64'd0);
        check_output("rst_data", 64'(o_data), 64'd0);
        @(negedge CLK);
        RSTn = 1'b1;
        model.delete();
        last_deq = '0;
    endtask

    task automatic apply_stimulus();
        int saw;
        // Directed: basic dequeue, ties, single entry, empty request.
        do_enqueue(7);
        do_enqueue(3);
        do_enqueue(9);
        check_state();
        check_mem();
        do_dequeue(1'b0, '0);
        check_mem();
        drain();
        do_enqueue(5);
        do_enqueue(2);
        do_enqueue(2);
        do_enqueue(8);
        do_dequeue(1'b0, '0);
        check_mem();
        do_dequeue(1'b0, '0);
        drain();
        do_enqueue(42);
        do_dequeue(1'b0, '0);
        do_dequeue(1'b0, '0);

        // Full queue, blocked enqueue, then simultaneous enqueue and dequeue.
        for (int i = 0; i < DEPTH; i++) do_enqueue(DW'(DEPTH - 1 - i));
        check_state();
        do_enqueue(77);
        check_state();
        do_dequeue(1'b0, '0);
        do_dequeue(1'b1, 99);
        check_mem();
        pulse_reset();

        // Randomised mix of operations with small values to provoke ties.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 2) != 0 && model.size() < DEPTH)
                do_enqueue(DW'($urandom_range(0, 20)));
            else
                do_dequeue(1'b0, '0);
        end
        check_state();
        check_mem();
        pulse_reset();

        // Reset in the middle of a scan aborts the dequeue.
        for (int i = 0; i < 10; i++) do_enqueue(DW'($urandom_range(100, 200)));
        @(negedge CLK);
        i_deq_req = 1'b1;
        @(posedge CLK);
        #1;
        i_deq_req = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        check_output("scan_busy", 64'(o_busy), 64'd1);
        pulse_reset();
        saw = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge CLK);
            #1;
            if (o_deq_valid) saw = 1;
        end
        check_output("no_pulse_after_abort", 64'(saw), 64'd0);
        check_state();
        do_enqueue(11);
        do_dequeue(1'b0, '0);
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        errors      = 0;
        checks      = 0;
        last_deq    = '0;
        i_enq_valid = 1'b0;
        i_enq_data  = '0;
        i_deq_req   = 1'b0;
        RSTn        = 1'b1;
        #2;
        RSTn = 1'b0;
        #1;
        check_output("init_count", 64'(o_count), 64'd0);
        check_output("init_empty", 64'(o_empty), 64'd1);
        check_output("init_busy", 64'(o_busy), 64'd0);
        check_output("init_deq_valid", 64'(o_deq_valid), 64'd0);
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        apply_stimulus();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
